// File: rtl/cam_pkg.sv
// rtl/cam_pkg.sv - shared frame-buffer state type, sizes and address packing
package cam_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SYNC,
        CAPTURE,
        SKIP
    } cam_state_t;

    localparam int FB_W  = 160;
    localparam int FB_H  = 120;
    localparam int FB_AW = 15;

    // Shared with the VGA read side so both agree on the RAM layout.
    function automatic logic [FB_AW-1:0] fb_addr(input logic [7:0] x, input logic [6:0] y);
        return {x, y};
    endfunction

endpackage

// File: rtl/cam_capture_if.sv
// rtl/cam_capture_if.sv - camera byte bus plus frame-RAM write port
interface cam_capture_if;
    import cam_pkg::*;

    logic             href;
    logic             vref;
    logic [7:0]       digital;
    logic             capture;
    logic [15:0]      pixel;
    logic [FB_AW-1:0] wraddr;
    logic             wren;
    logic             frame_done;
    logic             busy;

    modport master (
        output href, vref, digital, capture,
        input  pixel, wraddr, wren, frame_done, busy
    );

    modport slave (
        input  href, vref, digital, capture,
        output pixel, wraddr, wren, frame_done, busy
    );

endinterface

// File: rtl/cam_byte_pair.sv
// rtl/cam_byte_pair.sv - pairs consecutive camera bytes into 16-bit pixels
module cam_byte_pair (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        href,
    input  logic [7:0]  digital,
    output logic        pix_valid,
    output logic [15:0] pix_data
);

    logic       phase;
    logic [7:0] hi_byte;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase   <= 1'b0;
            hi_byte <= '0;
        end else begin
            phase <= href ? ~phase : 1'b0;
            if (href && !phase) begin
                hi_byte <= digital;
            end
        end
    end

    // Valid in the cycle the second byte is on the bus; the caller registers it.
    assign pix_valid = href & phase;
    assign pix_data  = {hi_byte, digital};

endmodule

// File: rtl/cam_capture.sv
// rtl/cam_capture.sv - frame sync, pixel counting and 4x decimation into the frame RAM
module cam_capture
    import cam_pkg::*;
#(
    parameter int SRC_W  = 640,
    parameter int SRC_H  = 480,
    parameter int DEC_SH = 2
) (
    input  logic      clk,
    input  logic      reset_n,
    cam_capture_if.slave bus
);

    localparam logic [9:0] COL_END = 10'(SRC_W);
    localparam logic [8:0] ROW_END = 9'(SRC_H);

    cam_state_t       state;
    logic             line_act;
    logic             line_d;
    logic             vref_d;
    logic             line_fall;
    logic             vref_fall;
    logic [9:0]       col;
    logic [8:0]       row;
    logic             pix_valid;
    logic [15:0]      pix_data;
    logic             keep;
    logic [7:0]       x_pos;
    logic [6:0]       y_pos;
    logic [15:0]      pixel_q;
    logic [FB_AW-1:0] wraddr_q;
    logic             wren_q;
    logic             frame_done_q;
    logic             busy_q;

    // vref overrides href: a line is only live while the frame sync is low.
    assign line_act  = bus.href & ~bus.vref;
    assign line_fall = line_d & ~line_act;
    assign vref_fall = vref_d & ~bus.vref;

    cam_byte_pair u_pair (
        .clk       (clk),
        .reset_n   (reset_n),
        .href      (line_act),
        .digital   (bus.digital),
        .pix_valid (pix_valid),
        .pix_data  (pix_data)
    );

    assign x_pos = 8'(col >> DEC_SH);
    assign y_pos = 7'(row >> DEC_SH);

    assign keep = pix_valid && (state == CAPTURE)
               && (col[DEC_SH-1:0] == '0) && (row[DEC_SH-1:0] == '0)
               && (col < COL_END) && (row < ROW_END);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            line_d <= 1'b0;
            vref_d <= 1'b0;
            col    <= '0;
            row    <= '0;
        end else begin
            line_d <= line_act;
            vref_d <= bus.vref;
            if (line_fall) begin
                col <= '0;
            end else if (pix_valid && col < COL_END) begin
                col <= col + 10'd1;
            end
            if (bus.vref) begin
                row <= '0;
            end else if (line_fall && row < ROW_END) begin
                row <= row + 9'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            pixel_q      <= '0;
            wraddr_q     <= '0;
            wren_q       <= 1'b0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            wren_q       <= keep;
            frame_done_q <= 1'b0;
            busy_q       <= (state == CAPTURE);
            if (keep) begin
                pixel_q  <= pix_data;
                wraddr_q <= fb_addr(x_pos, y_pos);
            end
            case (state)
                IDLE:    if (bus.vref) state <= SYNC;
                SYNC:    if (vref_fall) state <= bus.capture ? CAPTURE : SKIP;
                CAPTURE: if (bus.vref) begin
                             state        <= SYNC;
                             frame_done_q <= 1'b1;
                         end
                SKIP:    if (bus.vref) state <= SYNC;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.pixel      = pixel_q;
    assign bus.wraddr     = wraddr_q;
    assign bus.wren       = wren_q;
    assign bus.frame_done = frame_done_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_cam_capture.sv
// tb/tb_cam_capture.sv - randomized scoreboard bench for cam_capture
module tb_cam_capture;
    import cam_pkg::*;

    localparam int W  = 64;
    localparam int H  = 24;
    localparam int SH = 2;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    cam_capture_if bus ();

    cam_capture #(.SRC_W(W), .SRC_H(H), .DEC_SH(SH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        logic [14:0] addr;
        logic [15:0] pix;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          n_checks = 0;
    int          n_fail = 0;
    int          wr_count = 0;
    int          fd_count = 0;
    int          exp_fd = 0;
    logic [14:0] last_addr = '0;
    bit          prev_wren = 1'b0;
    bit          prev_fd = 1'b0;
    bit          model_cap = 1'b0;
    int          model_row = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: a pixel p of a line is stored iff the frame is captured, both
    // p and the line index are multiples of 4, and both are inside the source.
    function automatic void model_pixel(input int p, input logic [7:0] hi, input logic [7:0] lo);
        exp_t e;
        if (model_cap && p < W && model_row < H && p % 4 == 0 && model_row % 4 == 0) begin
            e.addr = {8'(p / 4), 7'(model_row / 4)};
            e.pix  = {hi, lo};
            exp_q.push_back(e);
        end
    endfunction

    task automatic send_line(input int nbytes, input int abort_at, input bit rnd);
        logic [7:0] hi;
        logic [7:0] b;
        hi = '0;
        for (int k = 0; k < nbytes; k++) begin
            if (k == abort_at) begin
                bus.vref = 1'b1;
                return;
            end
            b = rnd ? 8'($urandom) : 8'(k);
            bus.href = 1'b1;
            bus.digital = b;
            if (k % 2 == 0) hi = b;
            else model_pixel(k / 2, hi, b);
            tick();
        end
        bus.href = 1'b0;
        bus.digital = 8'($urandom);
        model_row++;
        repeat ($urandom_range(2, 6)) tick();
    endtask

    task automatic vref_pulse(input bit cap);
        bus.capture = cap;
        bus.vref = 1'b1;
        tick();
        bus.href = 1'b0;
        tick();
        tick();
        if (model_cap) exp_fd++;
        bus.vref = 1'b0;
        tick();
        model_cap = cap;
        model_row = 0;
        repeat (3) tick();
    endtask

    always @(negedge clk) begin
        if (bus.wren) begin
            wr_count++;
            last_addr = bus.wraddr;
            chk("wren_spacing", 32'(prev_wren), 32'd0);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: got addr 0x%0h pixel 0x%0h, required no write",
                         bus.wraddr, bus.pixel);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wr_addr", 32'(bus.wraddr), 32'(mon_e.addr));
                chk("wr_pixel", 32'(bus.pixel), 32'(mon_e.pix));
            end
        end
        if (bus.frame_done) begin
            fd_count++;
            chk("frame_done_single", 32'(prev_fd), 32'd0);
        end
        prev_wren = bus.wren;
        prev_fd = bus.frame_done;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1);
    end

    initial begin
        bus.href = 1'b0;
        bus.vref = 1'b0;
        bus.digital = '0;
        bus.capture = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wren", 32'(bus.wren), 32'd0);
        chk("rst_pixel", 32'(bus.pixel), 32'd0);
        chk("rst_wraddr", 32'(bus.wraddr), 32'd0);
        chk("rst_frame_done", 32'(bus.frame_done), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        reset_n = 1'b1;
        repeat (2) tick();

        // Single kept pixel: wren one cycle after the second byte is sampled.
        vref_pulse(1'b1);
        bus.href = 1'b1;
        bus.digital = 8'h5A;
        tick();
        bus.digital = 8'hC3;
        model_pixel(0, 8'h5A, 8'hC3);
        tick();
        bus.href = 1'b0;
        chk("lat_wren_high", 32'(bus.wren), 32'd1);
        chk("lat_pixel", 32'(bus.pixel), 32'h5AC3);
        chk("lat_wraddr", 32'(bus.wraddr), 32'd0);
        tick();
        chk("lat_wren_low", 32'(bus.wren), 32'd0);
        model_row++;
        repeat (4) tick();
        vref_pulse(1'b1);

        // Full frame with byte k = k[7:0], extra lines past the source height.
        wr_count = 0;
        for (int r = 0; r < H + 4; r++) send_line(2 * W, -1, 1'b0);
        chk("full_busy", 32'(bus.busy), 32'd1);
        vref_pulse(1'b1);
        chk("full_write_count", 32'(wr_count), 32'((W / 4) * (H / 4)));
        chk("full_last_addr", 32'(last_addr), 32'({8'(W / 4 - 1), 7'(H / 4 - 1)}));
        chk("full_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("full_frame_done", 32'(fd_count), 32'(exp_fd));

        // Overlong and odd-length lines.
        for (int r = 0; r < H; r++) begin
            send_line((r == 0) ? 2 * W + 3 : (r == 4) ? 2 * W + 1 : (r == 8) ? 17 : 2 * W,
                      -1, 1'b1);
        end
        vref_pulse(1'b0);
        chk("odd_queue_empty", 32'(exp_q.size()), 32'd0);

        // Frozen frame; capture raised mid-frame must not matter.
        wr_count = 0;
        repeat (5) tick();
        chk("freeze_busy_early", 32'(bus.busy), 32'd0);
        bus.capture = 1'b1;
        for (int r = 0; r < H; r++) send_line(2 * W, -1, 1'b1);
        chk("freeze_busy_late", 32'(bus.busy), 32'd0);
        chk("freeze_no_writes", 32'(wr_count), 32'd0);
        vref_pulse(1'b1);
        chk("freeze_frame_done", 32'(fd_count), 32'(exp_fd));

        // Written frame aborted by vref at line 8, byte 30.
        wr_count = 0;
        for (int r = 0; r < 8; r++) send_line(2 * W, -1, 1'b1);
        chk("abort_busy", 32'(bus.busy), 32'd1);
        send_line(2 * W, 30, 1'b1);
        vref_pulse(1'b1);
        chk("abort_write_count", 32'(wr_count), 32'(2 * (W / 4) + 4));
        chk("abort_frame_done", 32'(fd_count), 32'(exp_fd));
        chk("abort_queue_empty", 32'(exp_q.size()), 32'd0);

        // Reset during CAPTURE, coincident with a kept pixel's second byte.
        bus.href = 1'b1;
        bus.digital = 8'hA5;
        tick();
        bus.digital = 8'h3C;
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        chk("mid_rst_wren", 32'(bus.wren), 32'd0);
        chk("mid_rst_pixel", 32'(bus.pixel), 32'd0);
        chk("mid_rst_wraddr", 32'(bus.wraddr), 32'd0);
        chk("mid_rst_frame_done", 32'(bus.frame_done), 32'd0);
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        model_cap = 1'b0;
        model_row = 0;
        send_line(20, -1, 1'b1);
        for (int r = 0; r < 4; r++) send_line(2 * W, -1, 1'b1);
        chk("post_rst_idle_busy", 32'(bus.busy), 32'd0);
        vref_pulse(1'b1);
        for (int r = 0; r < 5; r++) send_line(2 * W, -1, 1'b1);
        chk("resume_busy", 32'(bus.busy), 32'd1);
        vref_pulse($urandom_range(0, 1) == 1);

        // Randomized frames: random capture, line counts and line lengths.
        for (int f = 0; f < 3; f++) begin
            for (int r = 0; r < H - 2 + int'($urandom_range(0, 5)); r++) begin
                send_line(2 * W - 9 + int'($urandom_range(0, 14)), -1, 1'b1);
            end
            vref_pulse($urandom_range(0, 1) == 1);
        end

        repeat (10) tick();
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("final_frame_done", 32'(fd_count), 32'(exp_fd));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
